imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
Boot/reload sequencer for the single-cycle core's instruction memory. Accepts a stream of 32-bit program words over a valid/ready interface and writes them into consecutive word slots of the instruction memory. Holds the core (PC, instruction memory read port) in reset while loading, then releases it. Sits between the external loader (UART/JTAG bridge or testbench) and the instruction memory write port plus core reset.

Parameters:
DEPTH, 32, number of 32-bit words in instruction memory
ADDR_W, 5, word-address width, equal to log2(DEPTH)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
load_start  in  1  single-cycle request to begin a load
load_len  in  ADDR_W+1  number of words to load; sampled with load_start
s_valid  in  1  program word valid
s_data  in  32  program word
s_ready  out  1  controller accepts a word this cycle
mem_we  out  1  instruction memory write enable
mem_waddr  out  ADDR_W  word address of the write
mem_wdata  out  32  write data
core_rst_n  out  1  active-low reset to PC/instruction memory read port; 0 = core held
busy  out  1  high in LOAD and RELEASE
done  out  1  one-cycle pulse when the load completes
err  out  1  sticky bad-length flag

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, count=0, s_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, core_rst_n=0, busy=0, done=0, err=0. Reset overrides everything, including mid-load. Partially written memory contents are undefined.
- All outputs are registered except s_ready, which is decoded from state: s_ready = (state==LOAD).
- States: IDLE, LOAD, RELEASE, RUN.
- IDLE: core_rst_n=0.
  - load_start with 1 <= load_len <= DEPTH: latch len, count=0, err=0, go to LOAD.
  - load_start with load_len==0 or load_len>DEPTH: err=1, stay in IDLE.
- LOAD: core_rst_n=0, busy=1.
  - A beat is accepted when s_valid && s_ready.
  - Accepted beat in cycle k: in cycle k+1, mem_we=1, mem_waddr=count[ADDR_W-1:0], mem_wdata=s_data; count increments.
  - mem_we=0 in any cycle that follows a cycle with no accepted beat.
  - When the beat with count==len-1 is accepted, go to RELEASE.
  - load_start is ignored in LOAD.
- RELEASE: exactly one cycle; busy=1, core_rst_n=0, done=1. The last write occurs in this cycle. Next state is RUN.
- RUN: core_rst_n=1, busy=0. The core fetches from address 0 on its first unreset cycle.
  - load_start with a valid length: go to LOAD. core_rst_n=0 from the next cycle and err clears.
  - load_start with an invalid length: err=1, stay in RUN with the core running.
- Write addresses run 0..len-1. With len==DEPTH the last address is DEPTH-1; count never wraps past len.
- err stays set until the next valid load_start or reset.
- Timing summary:
  - load_start at cycle 0 → s_ready=1 at cycle 1.
  - Last beat accepted at cycle k → done=1 and the last mem_we at cycle k+1 → core_rst_n=1 from cycle k+2.
- Memory writes are synchronous at clk. Write and fetch never coincide because the core is held in reset throughout LOAD and RELEASE.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then 1 → core_rst_n=0, s_ready=0, mem_we=0, err=0, state IDLE indefinitely.
- Basic load: load_start, load_len=3; stream FFC4A303, 0064A423, 0062E233 back-to-back → mem_we at 3 consecutive cycles with addresses 0,1,2 and matching data; done pulses with the third write; core_rst_n=1 the cycle after.
- Throttled source: load_len=2 with s_valid gaps of 2 cycles → mem_we only in cycles following accepted beats; addresses 0,1; done once.
- Bad length: load_len=0, then load_len=33 with DEPTH=32 → err=1, s_ready stays 0, no mem_we; a following valid load_start (len=1) → err=0 and load proceeds.
- Full depth and reload from RUN: load 32 words (last address 31, no wrap); in RUN issue load_start with len=1 → core_rst_n drops next cycle, single write to address 0, core released again.
- Reset mid-load: assert rst after 2 of 4 beats → all outputs at reset values next cycle; a new load_start restarts at address 0.

Source files
------------

// File: rtl/imem_load_if.sv
// Loader-side bundle for the instruction-memory load controller: program-word
// stream in, instruction-memory write port and core reset/status out.
//
// Handshake: a word on s_data is transferred in every cycle where s_valid and
// s_ready are both high at the rising edge of clk. The source may raise or drop
// s_valid freely. s_ready depends only on controller state, never on s_valid,
// so the source can look at it before deciding whether to present a word.
interface imem_load_if #(
  parameter int ADDR_W = 5
);
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  // Loader / bench side
  modport master (
    output load_start, load_len, s_valid, s_data,
    input  s_ready, mem_we, mem_waddr, mem_wdata, core_rst_n, busy, done, err
  );

  // Controller side
  modport slave (
    input  load_start, load_len, s_valid, s_data,
    output s_ready, mem_we, mem_waddr, mem_wdata, core_rst_n, busy, done, err
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Boot/reload sequencer: streams program words into consecutive instruction
// memory slots while holding the core in reset, then releases the core so it
// fetches from address 0. All outputs are registered except s_ready.
module imem_load_ctrl #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  imem_load_if.slave  bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              crn_q, crn_d;
  logic              len_ok;
  logic              accept;
  logic              last_beat;

  assign len_ok    = (bus.load_len != '0) && (bus.load_len <= DEPTH_L);
  assign accept    = (state_q == S_LOAD) && bus.s_valid;
  assign last_beat = (count_q == (len_q - CNT_ONE));

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.load_start) begin
          if (len_ok) begin
            len_d   = bus.load_len;
            count_d = '0;
            err_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            // Bad length: flag it but leave the core in its current state.
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = count_q[ADDR_W-1:0];
          wdata_d = bus.s_data;
          count_d = count_q + CNT_ONE;
          if (last_beat) begin
            state_d = S_RELEASE;
            done_d  = 1'b1;
          end
        end
      end
      S_RELEASE: state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
    // Status follows the state being entered so it lines up with that state.
    busy_d = (state_d == S_LOAD) || (state_d == S_RELEASE);
    crn_d  = (state_d == S_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      crn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      crn_q   <= crn_d;
    end
  end

  assign bus.s_ready    = (state_q == S_LOAD);
  assign bus.mem_we     = we_q;
  assign bus.mem_waddr  = waddr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_rst_n = crn_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl. A load is modelled as "word i of the stream lands
// at address i one cycle after it is handed over; done pulses with the last
// write; the core is released one cycle after that".
module tb_imem_load_ctrl;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         cyc;
  int         tests_run;
  int         tests_failed;

  imem_load_if #(.ADDR_W(ADDR_W)) bus ();

  imem_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0]       exp_q[$];      // words handed to the DUT, in order
  int                acc_cyc_q[$];  // cycle in which each word was handed over
  logic [31:0]       preset_q[$];   // fixed words the driver uses before random ones
  logic [ADDR_W-1:0] obs_addr_q[$];
  logic [31:0]       obs_data_q[$];
  int                obs_cyc_q[$];
  int                done_cyc_q[$];
  int                rise_cyc_q[$];
  logic              prev_crn;
  int                rdy_bad;
  int                timeout;
  logic              crn_after_start;
  logic              err_after_start;

  // Monitor: record every write, done pulse and core release.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      obs_addr_q.push_back(bus.mem_waddr);
      obs_data_q.push_back(bus.mem_wdata);
      obs_cyc_q.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cyc_q.push_back(cyc);
    if (bus.core_rst_n === 1'b1 && prev_crn !== 1'b1) rise_cyc_q.push_back(cyc);
    prev_crn = bus.core_rst_n;
  end

  task automatic clear_obs();
    obs_addr_q.delete();
    obs_data_q.delete();
    obs_cyc_q.delete();
    done_cyc_q.delete();
    rise_cyc_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive_load(input int len, input int min_gap, input int max_gap);
    int idx;
    int gap;
    int budget;
    logic [31:0] w;
    exp_q.delete();
    acc_cyc_q.delete();
    rdy_bad = 0;
    timeout = 0;
    @(negedge clk);
    clear_obs();
    bus.load_start = 1'b1;
    bus.load_len   = len[ADDR_W:0];
    @(negedge clk);
    bus.load_start  = 1'b0;
    crn_after_start = bus.core_rst_n;
    err_after_start = bus.err;
    idx    = 0;
    budget = 0;
    gap    = $urandom_range(max_gap, min_gap);
    while (idx < len && budget < 1000) begin
      if (bus.s_ready !== 1'b1) rdy_bad++;
      if (gap > 0) begin
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom;
        gap--;
      end else begin
        w = (idx < preset_q.size()) ? preset_q[idx] : $urandom;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        if (bus.s_ready === 1'b1) begin
          exp_q.push_back(w);
          acc_cyc_q.push_back(cyc);
          idx++;
          gap = $urandom_range(max_gap, min_gap);
        end
      end
      @(negedge clk);
      budget++;
    end
    bus.s_valid = 1'b0;
    if (budget >= 1000) timeout = 1;
    preset_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.s_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_waddr !== '0 ||
        bus.mem_wdata !== '0 || bus.core_rst_n !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%0d data=%h crn=%b busy=%b done=%b err=%b, required all 0",
               bus.s_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.core_rst_n,
               bus.busy, bus.done, bus.err);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.s_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.core_rst_n !== 1'b0 ||
          bus.busy !== 1'b0 || bus.err !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_hold[%0d]: rdy=%b we=%b crn=%b busy=%b err=%b, required all 0",
                 i, bus.s_ready, bus.mem_we, bus.core_rst_n, bus.busy, bus.err);
      end
    end
  endtask

  task automatic test_basic();
    preset_q = '{32'hFFC4A303, 32'h0064A423, 32'h0062E233};
    drive_load(3, 0, 0);
    tests_run++;
    if (rdy_bad != 0 || timeout != 0 || crn_after_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_ready: not_ready=%0d timeout=%0d crn=%b, required 0 0 0", rdy_bad, timeout, crn_after_start);
    end
    tests_run++;
    if (obs_addr_q.size() != 3 || acc_cyc_q.size() != 3) begin
      tests_failed++;
      $display("FAIL basic_count: writes=%0d accepted=%0d, required 3 3", obs_addr_q.size(), acc_cyc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (obs_addr_q[i] !== i[ADDR_W-1:0] || obs_data_q[i] !== exp_q[i] ||
            obs_cyc_q[i] != acc_cyc_q[0] + 1 + i) begin
          tests_failed++;
          $display("FAIL basic_write[%0d]: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   i, obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], i, exp_q[i], acc_cyc_q[0] + 1 + i);
        end
      end
      tests_run++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != obs_cyc_q[2] ||
          rise_cyc_q.size() != 1 || rise_cyc_q[0] != obs_cyc_q[2] + 1) begin
        tests_failed++;
        $display("FAIL basic_done_release: dones=%0d releases=%0d, required 1 done at cyc %0d, release at %0d",
                 done_cyc_q.size(), rise_cyc_q.size(), obs_cyc_q[2], obs_cyc_q[2] + 1);
      end
    end
    tests_run++;
    if (bus.core_rst_n !== 1'b1 || bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_run: crn=%b busy=%b rdy=%b, required 1 0 0", bus.core_rst_n, bus.busy, bus.s_ready);
    end
  endtask

  task automatic test_throttled();
    drive_load(2, 2, 2);
    tests_run++;
    if (rdy_bad != 0 || timeout != 0 || obs_addr_q.size() != 2 || exp_q.size() != 2) begin
      tests_failed++;
      $display("FAIL throttle_count: not_ready=%0d timeout=%0d writes=%0d, required 0 0 2",
               rdy_bad, timeout, obs_addr_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs_addr_q[i] !== i[ADDR_W-1:0] || obs_data_q[i] !== exp_q[i] ||
            obs_cyc_q[i] != acc_cyc_q[i] + 1) begin
          tests_failed++;
          $display("FAIL throttle_write[%0d]: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   i, obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], i, exp_q[i], acc_cyc_q[i] + 1);
        end
      end
      tests_run++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != acc_cyc_q[1] + 1) begin
        tests_failed++;
        $display("FAIL throttle_done: dones=%0d, required exactly 1 at cyc %0d", done_cyc_q.size(), acc_cyc_q[1] + 1);
      end
    end
  endtask

  task automatic test_bad_length();
    @(negedge clk);
    clear_obs();
    bus.load_start = 1'b1;
    bus.load_len   = '0;
    @(negedge clk);
    bus.load_start = 1'b0;
    tests_run++;
    if (bus.err !== 1'b1 || bus.s_ready !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_len_zero: err=%b rdy=%b busy=%b, required 1 0 0", bus.err, bus.s_ready, bus.busy);
    end
    bus.load_start = 1'b1;
    bus.load_len   = 6'd33;
    @(negedge clk);
    bus.load_start = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.err !== 1'b1 || bus.s_ready !== 1'b0 || obs_addr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bad_len_33: err=%b rdy=%b writes=%0d, required 1 0 0", bus.err, bus.s_ready, obs_addr_q.size());
    end
    drive_load(1, 0, 0);
    tests_run++;
    if (err_after_start !== 1'b0 || obs_addr_q.size() != 1 || exp_q.size() != 1) begin
      tests_failed++;
      $display("FAIL bad_len_recover: err=%b writes=%0d, required err 0 and 1 write", err_after_start, obs_addr_q.size());
    end else begin
      tests_run++;
      if (obs_addr_q[0] !== '0 || obs_data_q[0] !== exp_q[0] || bus.core_rst_n !== 1'b1) begin
        tests_failed++;
        $display("FAIL bad_len_write: addr=%0d data=%h crn=%b, required 0 %h 1", obs_addr_q[0], obs_data_q[0], bus.core_rst_n, exp_q[0]);
      end
    end
  endtask

  task automatic test_full_depth_reload();
    drive_load(DEPTH, 0, 1);
    tests_run++;
    if (rdy_bad != 0 || timeout != 0 || obs_addr_q.size() != DEPTH || exp_q.size() != DEPTH) begin
      tests_failed++;
      $display("FAIL full_count: not_ready=%0d timeout=%0d writes=%0d, required 0 0 %0d",
               rdy_bad, timeout, obs_addr_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        tests_run++;
        if (obs_addr_q[i] !== i[ADDR_W-1:0] || obs_data_q[i] !== exp_q[i] ||
            obs_cyc_q[i] != acc_cyc_q[i] + 1) begin
          tests_failed++;
          $display("FAIL full_write[%0d]: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   i, obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], i, exp_q[i], acc_cyc_q[i] + 1);
        end
      end
      tests_run++;
      if (done_cyc_q.size() != 1 || rise_cyc_q.size() != 1 || rise_cyc_q[0] != acc_cyc_q[DEPTH-1] + 2) begin
        tests_failed++;
        $display("FAIL full_release: dones=%0d releases=%0d, required 1 and release at %0d",
                 done_cyc_q.size(), rise_cyc_q.size(), acc_cyc_q[DEPTH-1] + 2);
      end
    end
    // Reload from RUN with a single word.
    tests_run++;
    if (bus.core_rst_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_pre_run: crn=%b, required 1", bus.core_rst_n);
    end
    drive_load(1, 0, 0);
    tests_run++;
    if (crn_after_start !== 1'b0 || obs_addr_q.size() != 1 || exp_q.size() != 1) begin
      tests_failed++;
      $display("FAIL reload_hold: crn=%b writes=%0d, required 0 and 1 write", crn_after_start, obs_addr_q.size());
    end else begin
      tests_run++;
      if (obs_addr_q[0] !== '0 || obs_data_q[0] !== exp_q[0] || rise_cyc_q.size() != 1 || bus.core_rst_n !== 1'b1) begin
        tests_failed++;
        $display("FAIL reload_write: addr=%0d data=%h releases=%0d crn=%b, required 0 %h 1 1",
                 obs_addr_q[0], obs_data_q[0], rise_cyc_q.size(), bus.core_rst_n, exp_q[0]);
      end
    end
    // Invalid request while running: flag only, core keeps running.
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_len   = 6'd40;
    @(negedge clk);
    bus.load_start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.err !== 1'b1 || bus.core_rst_n !== 1'b1 || bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL run_bad_len: err=%b crn=%b busy=%b rdy=%b, required 1 1 0 0",
               bus.err, bus.core_rst_n, bus.busy, bus.s_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    int got;
    int budget;
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_len   = 6'd4;
    @(negedge clk);
    bus.load_start = 1'b0;
    got    = 0;
    budget = 0;
    while (got < 2 && budget < 50) begin
      bus.s_valid = 1'b1;
      bus.s_data  = $urandom;
      if (bus.s_ready === 1'b1) got++;
      @(negedge clk);
      budget++;
    end
    // Third beat offered in the same cycle reset is applied.
    bus.s_valid = 1'b1;
    bus.s_data  = $urandom;
    rst = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b0;
    tests_run++;
    if (bus.s_ready !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_waddr !== '0 ||
        bus.mem_wdata !== '0 || bus.core_rst_n !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.err !== 1'b0 || got != 2) begin
      tests_failed++;
      $display("FAIL midload_reset: beats=%0d rdy=%b we=%b addr=%0d data=%h crn=%b busy=%b done=%b err=%b, required 2 beats and all 0",
               got, bus.s_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.core_rst_n,
               bus.busy, bus.done, bus.err);
    end
    rst = 1'b1;
    drive_load(2, 0, 1);
    tests_run++;
    if (obs_addr_q.size() != 2 || exp_q.size() != 2) begin
      tests_failed++;
      $display("FAIL midload_restart_count: writes=%0d, required 2", obs_addr_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs_addr_q[i] !== i[ADDR_W-1:0] || obs_data_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL midload_restart[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                   i, obs_addr_q[i], obs_data_q[i], i, exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cyc            = 0;
    tests_run      = 0;
    tests_failed   = 0;
    prev_crn       = 1'b0;
    rst            = 1'b0;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    test_reset();
    test_basic();
    test_throttled();
    test_bad_length();
    test_full_depth_reload();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
